// File: rtl/hazard_pipe_tracker.sv
// hazard_pipe_tracker
//   Source side of the hazard interface. Carries register IDs and the RegWrite/MemtoReg
//   controls from decode through the E, M and W pipeline registers and presents them to the
//   hazard unit. The hazard unit answers with Stall_D/Flush_E, applied here as a bubble into E.
//   Saturating counters record stall, flush and retire events for performance debug.
//
// Ports
//   CLK, RST                 rising-edge clock, synchronous active-low reset
//   Valid_D                  decode holds a real instruction
//   Rs_D, Rt_D, Rd_D         decode register fields
//   RegDst_D                 1: write reg = rd, 0: write reg = rt
//   RegWrite_D, MemtoReg_D   decode control bits
//   Stall_D, Flush_E         from hazard unit
//   Clr_Cnt                  synchronous clear of all event counters
//   Rs_E, Rt_E               E-stage source registers
//   OUTmux2_A3/3/4           write register in E/M/W
//   RegWrite_2/3/4           RegWrite in E/M/W, qualified by stage valid
//   MemtoReg_2/3             MemtoReg in E/M, qualified by stage valid
//   Stall_Cnt, Flush_Cnt,
//   Retire_Cnt               saturating event counters

module hazard_pipe_tracker #(
  parameter int unsigned REGW  = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Valid_D,
  input  logic [REGW-1:0]  Rs_D,
  input  logic [REGW-1:0]  Rt_D,
  input  logic [REGW-1:0]  Rd_D,
  input  logic             RegDst_D,
  input  logic             RegWrite_D,
  input  logic             MemtoReg_D,
  input  logic             Stall_D,
  input  logic             Flush_E,
  input  logic             Clr_Cnt,
  output logic [REGW-1:0]  Rs_E,
  output logic [REGW-1:0]  Rt_E,
  output logic [REGW-1:0]  OUTmux2_A3,
  output logic [REGW-1:0]  OUTmux3_A3,
  output logic [REGW-1:0]  OUTmux4_A3,
  output logic             RegWrite_2,
  output logic             RegWrite_3,
  output logic             RegWrite_4,
  output logic             MemtoReg_2,
  output logic             MemtoReg_3,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt,
  output logic [CNT_W-1:0] Retire_Cnt
);

  // E stage
  logic            valid_e_q;
  logic [REGW-1:0] rs_e_q, rt_e_q, rd_e_q;
  logic            regdst_e_q, regwrite_e_q, memtoreg_e_q;
  logic [REGW-1:0] wreg_e;

  // M stage
  logic            valid_m_q;
  logic [REGW-1:0] wreg_m_q;
  logic            regwrite_m_q, memtoreg_m_q;

  // W stage
  logic            valid_w_q;
  logic [REGW-1:0] wreg_w_q;
  logic            regwrite_w_q;

  // Event counters
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  logic stall_ev, flush_ev, retire_ev;

  // Write-register select is combinational off the E registers so the hazard unit sees it
  // in the same cycle the instruction sits in E.
  assign wreg_e = regdst_e_q ? rd_e_q : rt_e_q;

  // D->E register. Flush wins over stall; stall alone does not hold E since the hazard unit
  // always pairs a decode stall with an E flush.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      valid_e_q    <= 1'b0;
      rs_e_q       <= '0;
      rt_e_q       <= '0;
      rd_e_q       <= '0;
      regdst_e_q   <= 1'b0;
      regwrite_e_q <= 1'b0;
      memtoreg_e_q <= 1'b0;
    end else if (Flush_E) begin
      valid_e_q    <= 1'b0;
      rs_e_q       <= '0;
      rt_e_q       <= '0;
      rd_e_q       <= '0;
      regdst_e_q   <= 1'b0;
      regwrite_e_q <= 1'b0;
      memtoreg_e_q <= 1'b0;
    end else begin
      valid_e_q    <= Valid_D;
      rs_e_q       <= Rs_D;
      rt_e_q       <= Rt_D;
      rd_e_q       <= Rd_D;
      regdst_e_q   <= RegDst_D;
      regwrite_e_q <= RegWrite_D;
      memtoreg_e_q <= MemtoReg_D;
    end
  end

  // E->M and M->W advance every edge; these stages never stall.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      valid_m_q    <= 1'b0;
      wreg_m_q     <= '0;
      regwrite_m_q <= 1'b0;
      memtoreg_m_q <= 1'b0;
      valid_w_q    <= 1'b0;
      wreg_w_q     <= '0;
      regwrite_w_q <= 1'b0;
    end else begin
      valid_m_q    <= valid_e_q;
      wreg_m_q     <= wreg_e;
      regwrite_m_q <= regwrite_e_q;
      memtoreg_m_q <= memtoreg_e_q;
      valid_w_q    <= valid_m_q;
      wreg_w_q     <= wreg_m_q;
      regwrite_w_q <= regwrite_m_q;
    end
  end

  // A flush paired with a stall is a load-use bubble, not a control-flow flush.
  assign stall_ev  = Stall_D;
  assign flush_ev  = Flush_E & ~Stall_D;
  assign retire_ev = valid_w_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic ev);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (ev && (cnt != {CNT_W{1'b1}})) begin
      res = cnt + 1'b1;
    end
    return res;
  endfunction

  always_comb begin
    stall_cnt_d  = sat_inc(stall_cnt_q, stall_ev);
    flush_cnt_d  = sat_inc(flush_cnt_q, flush_ev);
    retire_cnt_d = sat_inc(retire_cnt_q, retire_ev);
    if (Clr_Cnt) begin
      stall_cnt_d  = '0;
      flush_cnt_d  = '0;
      retire_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign Rs_E       = rs_e_q;
  assign Rt_E       = rt_e_q;
  assign OUTmux2_A3 = wreg_e;
  assign OUTmux3_A3 = wreg_m_q;
  assign OUTmux4_A3 = wreg_w_q;

  // Controls are qualified by stage valid so a bubble can never request a write or a load.
  assign RegWrite_2 = valid_e_q & regwrite_e_q;
  assign RegWrite_3 = valid_m_q & regwrite_m_q;
  assign RegWrite_4 = valid_w_q & regwrite_w_q;
  assign MemtoReg_2 = valid_e_q & memtoreg_e_q;
  assign MemtoReg_3 = valid_m_q & memtoreg_m_q;

  assign Stall_Cnt  = stall_cnt_q;
  assign Flush_Cnt  = flush_cnt_q;
  assign Retire_Cnt = retire_cnt_q;

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
module tb_hazard_pipe_tracker;

  localparam int unsigned REGW  = 5;
  localparam int unsigned CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             Valid_D;
  logic [REGW-1:0]  Rs_D, Rt_D, Rd_D;
  logic             RegDst_D, RegWrite_D, MemtoReg_D;
  logic             Stall_D, Flush_E, Clr_Cnt;
  logic [REGW-1:0]  Rs_E, Rt_E, OUTmux2_A3, OUTmux3_A3, OUTmux4_A3;
  logic             RegWrite_2, RegWrite_3, RegWrite_4, MemtoReg_2, MemtoReg_3;
  logic [CNT_W-1:0] Stall_Cnt, Flush_Cnt, Retire_Cnt;

  int n_total = 0;
  int n_bad   = 0;

  always #5 CLK = ~CLK;

  hazard_pipe_tracker #(
    .REGW  (REGW),
    .CNT_W (CNT_W)
  ) u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .Valid_D    (Valid_D),
    .Rs_D       (Rs_D),
    .Rt_D       (Rt_D),
    .Rd_D       (Rd_D),
    .RegDst_D   (RegDst_D),
    .RegWrite_D (RegWrite_D),
    .MemtoReg_D (MemtoReg_D),
    .Stall_D    (Stall_D),
    .Flush_E    (Flush_E),
    .Clr_Cnt    (Clr_Cnt),
    .Rs_E       (Rs_E),
    .Rt_E       (Rt_E),
    .OUTmux2_A3 (OUTmux2_A3),
    .OUTmux3_A3 (OUTmux3_A3),
    .OUTmux4_A3 (OUTmux4_A3),
    .RegWrite_2 (RegWrite_2),
    .RegWrite_3 (RegWrite_3),
    .RegWrite_4 (RegWrite_4),
    .MemtoReg_2 (MemtoReg_2),
    .MemtoReg_3 (MemtoReg_3),
    .Stall_Cnt  (Stall_Cnt),
    .Flush_Cnt  (Flush_Cnt),
    .Retire_Cnt (Retire_Cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_instr(input logic v, input int rs, input int rt, input int rd,
                             input logic dst, input logic rw, input logic mtr);
    Valid_D    = v;
    Rs_D       = REGW'(rs);
    Rt_D       = REGW'(rt);
    Rd_D       = REGW'(rd);
    RegDst_D   = dst;
    RegWrite_D = rw;
    MemtoReg_D = mtr;
  endtask

  task automatic drive_idle();
    drive_instr(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    Stall_D = 1'b0;
    Flush_E = 1'b0;
    Clr_Cnt = 1'b0;
  endtask

  initial begin
    // 1: reset with random inputs
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_instr($urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1);
      Stall_D = $urandom_range(0, 1) == 1;
      Flush_E = $urandom_range(0, 1) == 1;
      Clr_Cnt = $urandom_range(0, 1) == 1;
      tick();
    end
    check_eq("rst_rs_e", Rs_E, 0);
    check_eq("rst_mux2", OUTmux2_A3, 0);
    check_eq("rst_mux3", OUTmux3_A3, 0);
    check_eq("rst_mux4", OUTmux4_A3, 0);
    check_eq("rst_ctl", {RegWrite_2, RegWrite_3, RegWrite_4, MemtoReg_2, MemtoReg_3}, 0);
    check_eq("rst_cnt", {Stall_Cnt, Flush_Cnt, Retire_Cnt}, 0);

    // 2: add $3,$1,$2 streams through
    RST = 1'b1;
    drive_idle();
    drive_instr(1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b0);
    tick();
    check_eq("add_rs_e", Rs_E, 1);
    check_eq("add_rt_e", Rt_E, 2);
    check_eq("add_mux2", OUTmux2_A3, 3);
    check_eq("add_rw2", RegWrite_2, 1);
    check_eq("add_rw3_e_only", RegWrite_3, 0);
    check_eq("add_mux3_e_only", OUTmux3_A3, 0);
    drive_idle();
    tick();
    check_eq("add_mux3", OUTmux3_A3, 3);
    check_eq("add_rw3", RegWrite_3, 1);
    check_eq("add_rw2_idle", RegWrite_2, 0);
    tick();
    check_eq("add_mux4", OUTmux4_A3, 3);
    check_eq("add_rw4", RegWrite_4, 1);
    check_eq("add_ret_early", Retire_Cnt, 0);
    tick();
    check_eq("add_retire", Retire_Cnt, 1);
    check_eq("add_rw4_gone", RegWrite_4, 0);

    // 3: lw $5 followed by a load-use stall
    drive_instr(1'b1, 4, 5, 0, 1'b0, 1'b1, 1'b1);
    tick();
    check_eq("lw_mux2", OUTmux2_A3, 5);
    check_eq("lw_mtr2", MemtoReg_2, 1);
    drive_instr(1'b1, 5, 1, 6, 1'b1, 1'b1, 1'b0);
    Stall_D = 1'b1;
    Flush_E = 1'b1;
    tick();
    check_eq("lu_bub_rw2", RegWrite_2, 0);
    check_eq("lu_bub_mtr2", MemtoReg_2, 0);
    check_eq("lu_bub_rs_e", Rs_E, 0);
    check_eq("lu_mtr3", MemtoReg_3, 1);
    check_eq("lu_mux3", OUTmux3_A3, 5);
    check_eq("lu_stall_cnt", Stall_Cnt, 1);
    check_eq("lu_flush_cnt", Flush_Cnt, 0);
    Stall_D = 1'b0;
    Flush_E = 1'b0;
    tick();
    check_eq("lu_dep_mux2", OUTmux2_A3, 6);
    check_eq("lu_bub_rw3", RegWrite_3, 0);
    check_eq("lu_bub_mtr3", MemtoReg_3, 0);
    check_eq("lu_lw_mux4", OUTmux4_A3, 5);
    check_eq("lu_lw_rw4", RegWrite_4, 1);
    drive_idle();
    tick();
    check_eq("lu_ret_lw", Retire_Cnt, 2);
    tick();
    tick();
    check_eq("lu_ret_dep", Retire_Cnt, 3);

    // 4: control-flow flush
    drive_instr(1'b1, 0, 7, 0, 1'b0, 1'b1, 1'b0);
    Flush_E = 1'b1;
    tick();
    check_eq("jf_rw2", RegWrite_2, 0);
    check_eq("jf_mux2", OUTmux2_A3, 0);
    check_eq("jf_flush_cnt", Flush_Cnt, 1);
    check_eq("jf_stall_cnt", Stall_Cnt, 1);
    drive_idle();
    for (int i = 0; i < 3; i++) tick();
    check_eq("jf_no_retire", Retire_Cnt, 3);

    // 5: stall counter saturates, clear beats increment
    Stall_D = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    check_eq("sat_pre", Stall_Cnt, 14);
    for (int i = 0; i < 7; i++) tick();
    check_eq("sat_hold", Stall_Cnt, 15);
    Clr_Cnt = 1'b1;
    tick();
    check_eq("clr_stall", Stall_Cnt, 0);
    check_eq("clr_flush", Flush_Cnt, 0);
    check_eq("clr_retire", Retire_Cnt, 0);
    drive_idle();

    // 6: reset with three instructions in flight
    drive_instr(1'b1, 1, 8, 0, 1'b0, 1'b1, 1'b0);
    tick();
    drive_instr(1'b1, 2, 9, 0, 1'b0, 1'b1, 1'b0);
    tick();
    drive_instr(1'b1, 3, 10, 0, 1'b0, 1'b1, 1'b1);
    tick();
    check_eq("mid_inflight", {RegWrite_2, RegWrite_3, RegWrite_4}, 3'b111);
    check_eq("mid_mux4", OUTmux4_A3, 8);
    drive_idle();
    RST = 1'b0;
    tick();
    check_eq("mid_rst_ctl", {RegWrite_2, RegWrite_3, RegWrite_4, MemtoReg_2, MemtoReg_3}, 0);
    check_eq("mid_rst_mux4", OUTmux4_A3, 0);
    check_eq("mid_rst_ret", Retire_Cnt, 0);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("mid_no_late_rw4", RegWrite_4, 0);
    end
    check_eq("mid_ret_final", Retire_Cnt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
